axi_lite_reg_slave: RTL and testbench

AXI_LITE_REG_SLAVE -- requirements
Module: axi_lite_reg_slave

---
 rtl/axi_lite_reg_slave_if.sv | 57 +++++
 rtl/axi_lite_reg_slave.sv | 186 ++++++++++++++++++
 tb/tb_axi_lite_reg_slave.sv | 341 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_reg_slave_if.sv
// AXI-lite response codes and the AXI-lite channel bundle (AW, W, B, AR, R).
// The bundle also carries the clock and active-low reset shared by both ends.
package axi_common;
  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_t;
endpackage

interface axi_lite_channel #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input logic clk,
  input logic rstn
);
  // Handshake rule on every channel: a transfer happens on a rising edge where
  // valid and ready are both 1. A source that raises valid holds valid and its
  // payload stable until that transfer; ready may rise and fall at any time.
  logic                    aw_valid;
  logic                    aw_ready;
  logic [ADDR_WIDTH-1:0]   aw_addr;
  logic                    w_valid;
  logic                    w_ready;
  logic [DATA_WIDTH-1:0]   w_data;
  logic [DATA_WIDTH/8-1:0] w_strb;
  logic                    b_valid;
  logic                    b_ready;
  axi_common::resp_t       b_resp;
  logic                    ar_valid;
  logic                    ar_ready;
  logic [ADDR_WIDTH-1:0]   ar_addr;
  logic                    r_valid;
  logic                    r_ready;
  logic [DATA_WIDTH-1:0]   r_data;
  axi_common::resp_t       r_resp;

  modport slave (
    input  clk, rstn,
    input  aw_valid, aw_addr, output aw_ready,
    input  w_valid, w_data, w_strb, output w_ready,
    output b_valid, b_resp, input b_ready,
    input  ar_valid, ar_addr, output ar_ready,
    output r_valid, r_data, r_resp, input r_ready
  );

  modport master (
    input  clk, rstn,
    output aw_valid, aw_addr, input aw_ready,
    output w_valid, w_data, w_strb, input w_ready,
    input  b_valid, b_resp, output b_ready,
    output ar_valid, ar_addr, input ar_ready,
    input  r_valid, r_data, r_resp, output r_ready
  );
endinterface

// File: rtl/axi_lite_reg_slave.sv
// AXI-lite slave exposing NUM_REGS byte-strobed registers, with independent
// write (AW/W/B) and read (AR/R) paths, each good for one transfer per 2+ cycles.
module axi_lite_reg_slave #(
  parameter int                      NUM_REGS    = 16,
  parameter int                      DATA_WIDTH  = 32,
  parameter int                      ADDR_WIDTH  = 32,
  parameter logic [DATA_WIDTH-1:0]   RESET_VALUE = '0,
  parameter axi_common::resp_t       MISS_RESP   = axi_common::RESP_DECERR
) (
  axi_lite_channel.slave                master,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs,
  output logic [1:0]                    dbg_wr_state,
  output logic                          dbg_rd_state
);
  localparam int STRB_W   = DATA_WIDTH / 8;
  localparam int ADDR_LSB = $clog2(STRB_W);
  localparam int IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} wr_state_t;
  typedef enum logic       {R_IDLE, R_RESP} rd_state_t;

  wr_state_t             wr_state;
  rd_state_t             rd_state;
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];

  logic [ADDR_WIDTH-1:0] aw_addr_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [STRB_W-1:0]     w_strb_q;

  logic                  aw_hs, w_hs, ar_hs;
  logic [ADDR_WIDTH-1:0] wr_addr_eff;
  logic [DATA_WIDTH-1:0] wr_data_eff;
  logic [STRB_W-1:0]     wr_strb_eff;
  logic                  wr_commit;
  logic                  wr_hit, rd_hit;
  logic [IDX_W-1:0]      wr_idx, rd_idx;

  function automatic logic [ADDR_WIDTH-1:0] word_of(input logic [ADDR_WIDTH-1:0] a);
    return a >> ADDR_LSB;
  endfunction

  function automatic logic addr_hit(input logic [ADDR_WIDTH-1:0] a);
    return word_of(a) < ADDR_WIDTH'(NUM_REGS);
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] w;
    w = word_of(a);
    return w[IDX_W-1:0];
  endfunction

  assign aw_hs = master.aw_valid && master.aw_ready;
  assign w_hs  = master.w_valid  && master.w_ready;
  assign ar_hs = master.ar_valid && master.ar_ready;

  // A handshake completing this cycle supplies its payload directly, so the
  // commit can happen on the same edge as the later of the two handshakes.
  always_comb begin
    wr_addr_eff = aw_hs ? master.aw_addr : aw_addr_q;
    wr_data_eff = w_hs  ? master.w_data  : w_data_q;
    wr_strb_eff = w_hs  ? master.w_strb  : w_strb_q;
    wr_commit   = 1'b0;
    case (wr_state)
      W_IDLE:    wr_commit = aw_hs && w_hs;
      W_HAVE_AW: wr_commit = w_hs;
      W_HAVE_W:  wr_commit = aw_hs;
      default:   wr_commit = 1'b0;
    endcase
  end

  assign wr_hit = addr_hit(wr_addr_eff);
  assign wr_idx = addr_idx(wr_addr_eff);
  assign rd_hit = addr_hit(master.ar_addr);
  assign rd_idx = addr_idx(master.ar_addr);

  // Write channel FSM; aw_ready/w_ready/b_valid/b_resp are registered here.
  always_ff @(posedge master.clk or negedge master.rstn) begin
    if (!master.rstn) begin
      wr_state        <= W_IDLE;
      master.aw_ready <= 1'b1;
      master.w_ready  <= 1'b1;
      master.b_valid  <= 1'b0;
      master.b_resp   <= axi_common::RESP_OKAY;
      aw_addr_q       <= '0;
      w_data_q        <= '0;
      w_strb_q        <= '0;
    end else begin
      if (aw_hs) aw_addr_q <= master.aw_addr;
      if (w_hs) begin
        w_data_q <= master.w_data;
        w_strb_q <= master.w_strb;
      end
      case (wr_state)
        W_IDLE: begin
          if (aw_hs && w_hs) begin
            wr_state        <= W_RESP;
            master.aw_ready <= 1'b0;
            master.w_ready  <= 1'b0;
            master.b_valid  <= 1'b1;
            master.b_resp   <= wr_hit ? axi_common::RESP_OKAY : MISS_RESP;
          end else if (aw_hs) begin
            wr_state        <= W_HAVE_AW;
            master.aw_ready <= 1'b0;
          end else if (w_hs) begin
            wr_state        <= W_HAVE_W;
            master.w_ready  <= 1'b0;
          end
        end
        W_HAVE_AW: begin
          if (w_hs) begin
            wr_state        <= W_RESP;
            master.w_ready  <= 1'b0;
            master.b_valid  <= 1'b1;
            master.b_resp   <= wr_hit ? axi_common::RESP_OKAY : MISS_RESP;
          end
        end
        W_HAVE_W: begin
          if (aw_hs) begin
            wr_state        <= W_RESP;
            master.aw_ready <= 1'b0;
            master.b_valid  <= 1'b1;
            master.b_resp   <= wr_hit ? axi_common::RESP_OKAY : MISS_RESP;
          end
        end
        W_RESP: begin
          if (master.b_ready) begin
            wr_state        <= W_IDLE;
            master.aw_ready <= 1'b1;
            master.w_ready  <= 1'b1;
            master.b_valid  <= 1'b0;
          end
        end
        default: wr_state <= W_IDLE;
      endcase
    end
  end

  // Register file: bytes whose strobe is 0 keep their value; misses write nothing.
  always_ff @(posedge master.clk or negedge master.rstn) begin
    if (!master.rstn) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VALUE;
    end else if (wr_commit && wr_hit) begin
      for (int k = 0; k < STRB_W; k++) begin
        if (wr_strb_eff[k]) regs_q[wr_idx][k*8 +: 8] <= wr_data_eff[k*8 +: 8];
      end
    end
  end

  // Read channel FSM; r_data samples regs_q before any write landing on the same edge.
  always_ff @(posedge master.clk or negedge master.rstn) begin
    if (!master.rstn) begin
      rd_state        <= R_IDLE;
      master.ar_ready <= 1'b1;
      master.r_valid  <= 1'b0;
      master.r_data   <= '0;
      master.r_resp   <= axi_common::RESP_OKAY;
    end else begin
      case (rd_state)
        R_IDLE: begin
          if (ar_hs) begin
            rd_state        <= R_RESP;
            master.ar_ready <= 1'b0;
            master.r_valid  <= 1'b1;
            master.r_data   <= rd_hit ? regs_q[rd_idx] : '0;
            master.r_resp   <= rd_hit ? axi_common::RESP_OKAY : MISS_RESP;
          end
        end
        R_RESP: begin
          if (master.r_ready) begin
            rd_state        <= R_IDLE;
            master.ar_ready <= 1'b1;
            master.r_valid  <= 1'b0;
          end
        end
        default: rd_state <= R_IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_regs_out
    assign regs[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
  end

  assign dbg_wr_state = wr_state;
  assign dbg_rd_state = rd_state;
endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// Bench for axi_lite_reg_slave: directed scenarios plus randomized traffic checked
// against a word-array model of the register file.
module tb_axi_lite_reg_slave;
  import axi_common::*;

  localparam int NREG = 16;
  localparam int DW   = 32;

  logic              clk;
  logic              rstn;
  logic [NREG*DW-1:0] regs_o;
  logic [1:0]        dbg_wr_state;
  logic              dbg_rd_state;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [DW-1:0] model [NREG];

  axi_lite_channel #(.ADDR_WIDTH(32), .DATA_WIDTH(DW)) bus (.clk(clk), .rstn(rstn));

  axi_lite_reg_slave #(.NUM_REGS(NREG), .DATA_WIDTH(DW)) dut (
    .master       (bus),
    .regs         (regs_o),
    .dbg_wr_state (dbg_wr_state),
    .dbg_rd_state (dbg_rd_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  function automatic logic [NREG*DW-1:0] model_vec();
    logic [NREG*DW-1:0] v;
    for (int i = 0; i < NREG; i++) v[i*DW +: DW] = model[i];
    return v;
  endfunction

  function automatic resp_t model_write(input logic [31:0] addr, input logic [31:0] data,
                                        input logic [3:0] strb);
    logic [31:0] mask;
    int idx;
    idx = int'(addr / 4);
    if (idx >= NREG) return RESP_DECERR;
    mask = 32'h0;
    for (int b = 0; b < 4; b++) if (strb[b]) mask = mask | (32'hFF << (8 * b));
    model[idx] = (model[idx] & ~mask) | (data & mask);
    return RESP_OKAY;
  endfunction

  function automatic logic [31:0] model_read_data(input logic [31:0] addr);
    int idx;
    idx = int'(addr / 4);
    return (idx >= NREG) ? 32'h0 : model[idx];
  endfunction

  function automatic resp_t model_read_resp(input logic [31:0] addr);
    return (int'(addr / 4) >= NREG) ? RESP_DECERR : RESP_OKAY;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int aw_dly, input int w_dly,
                             input int b_dly, output resp_t resp, output bit ok);
    bit aw_done, w_done, aw_fire, w_fire;
    int cyc;
    aw_done = 0; w_done = 0; cyc = 0; ok = 1; resp = RESP_OKAY;
    while (!(aw_done && w_done) && cyc < 50) begin
      bus.aw_valid = !aw_done && (cyc >= aw_dly);
      bus.aw_addr  = addr;
      bus.w_valid  = !w_done && (cyc >= w_dly);
      bus.w_data   = data;
      bus.w_strb   = strb;
      aw_fire = bus.aw_valid && bus.aw_ready;
      w_fire  = bus.w_valid && bus.w_ready;
      step();
      if (aw_fire) aw_done = 1;
      if (w_fire)  w_done = 1;
      cyc++;
    end
    bus.aw_valid = 0;
    bus.w_valid  = 0;
    if (!(aw_done && w_done)) begin
      ok = 0;
      return;
    end
    repeat (b_dly) step();
    bus.b_ready = 1;
    cyc = 0;
    while (!bus.b_valid && cyc < 50) begin step(); cyc++; end
    ok   = bus.b_valid;
    resp = bus.b_resp;
    step();
    bus.b_ready = 0;
  endtask

  task automatic drive_read(input logic [31:0] addr, input int r_dly,
                            output logic [31:0] data, output resp_t resp, output bit ok);
    int cyc;
    ok = 1; data = '0; resp = RESP_OKAY;
    bus.ar_valid = 1;
    bus.ar_addr  = addr;
    cyc = 0;
    while (!bus.ar_ready && cyc < 50) begin step(); cyc++; end
    if (!bus.ar_ready) begin
      bus.ar_valid = 0;
      ok = 0;
      return;
    end
    step();
    bus.ar_valid = 0;
    repeat (r_dly) step();
    bus.r_ready = 1;
    cyc = 0;
    while (!bus.r_valid && cyc < 50) begin step(); cyc++; end
    ok   = bus.r_valid;
    data = bus.r_data;
    resp = bus.r_resp;
    step();
    bus.r_ready = 0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    n_cmp++; if (bus.aw_ready !== 1'b1) begin n_fail++; $display("FAIL reset_aw_ready: got %b want 1", bus.aw_ready); end
    n_cmp++; if (bus.w_ready !== 1'b1) begin n_fail++; $display("FAIL reset_w_ready: got %b want 1", bus.w_ready); end
    n_cmp++; if (bus.ar_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ar_ready: got %b want 1", bus.ar_ready); end
    n_cmp++; if (bus.b_valid !== 1'b0) begin n_fail++; $display("FAIL reset_b_valid: got %b want 0", bus.b_valid); end
    n_cmp++; if (bus.r_valid !== 1'b0) begin n_fail++; $display("FAIL reset_r_valid: got %b want 0", bus.r_valid); end
    n_cmp++; if (regs_o !== model_vec()) begin n_fail++; $display("FAIL reset_regs: got %h want %h", regs_o, model_vec()); end
  endtask

  task automatic test_same_cycle_write();
    resp_t er;
    er = model_write(32'h08, 32'hDEADBEEF, 4'hF);
    bus.aw_valid = 1; bus.aw_addr = 32'h08;
    bus.w_valid = 1; bus.w_data = 32'hDEADBEEF; bus.w_strb = 4'hF;
    step();
    bus.aw_valid = 0; bus.w_valid = 0;
    n_cmp++; if (bus.b_valid !== 1'b1) begin n_fail++; $display("FAIL same_b_valid: got %b want 1", bus.b_valid); end
    n_cmp++; if (bus.b_resp !== er) begin n_fail++; $display("FAIL same_b_resp: got %0d want %0d", bus.b_resp, er); end
    n_cmp++; if (regs_o[2*DW +: DW] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL same_reg2: got %h want deadbeef", regs_o[2*DW +: DW]); end
    n_cmp++; if ({bus.aw_ready, bus.w_ready} !== 2'b00) begin n_fail++; $display("FAIL same_ready_in_resp: got %b want 00", {bus.aw_ready, bus.w_ready}); end
    step(); step();
    n_cmp++; if (bus.b_valid !== 1'b1 || bus.b_resp !== er) begin n_fail++; $display("FAIL same_b_hold: got %b/%0d want 1/%0d", bus.b_valid, bus.b_resp, er); end
    bus.b_ready = 1;
    step();
    bus.b_ready = 0;
    n_cmp++; if ({bus.b_valid, bus.aw_ready, bus.w_ready} !== 3'b011) begin n_fail++; $display("FAIL same_after_b: got %b want 011", {bus.b_valid, bus.aw_ready, bus.w_ready}); end
    n_cmp++; if (regs_o !== model_vec()) begin n_fail++; $display("FAIL same_regs: got %h want %h", regs_o, model_vec()); end
  endtask

  task automatic test_staggered_write();
    resp_t r, er;
    bit ok;
    er = model_write(32'h04, 32'hAAAAAAAA, 4'hF);
    drive_write(32'h04, 32'hAAAAAAAA, 4'hF, 0, 0, 0, r, ok);
    n_cmp++; if (!ok || r !== er) begin n_fail++; $display("FAIL stag_prefill: ok %b resp %0d want ok 1 resp %0d", ok, r, er); end
    er = model_write(32'h04, 32'h12345678, 4'h3);
    bus.w_valid = 1; bus.w_data = 32'h12345678; bus.w_strb = 4'h3;
    step();
    bus.w_valid = 0;
    n_cmp++; if ({bus.w_ready, bus.aw_ready, bus.b_valid} !== 3'b010) begin n_fail++; $display("FAIL stag_have_w: got %b want 010", {bus.w_ready, bus.aw_ready, bus.b_valid}); end
    step(); step();
    n_cmp++; if (bus.b_valid !== 1'b0 || regs_o[1*DW +: DW] !== 32'hAAAAAAAA) begin n_fail++; $display("FAIL stag_wait: got b %b reg1 %h want 0 aaaaaaaa", bus.b_valid, regs_o[1*DW +: DW]); end
    bus.aw_valid = 1; bus.aw_addr = 32'h04;
    step();
    bus.aw_valid = 0;
    n_cmp++; if (bus.b_valid !== 1'b1 || bus.b_resp !== er) begin n_fail++; $display("FAIL stag_b: got %b/%0d want 1/%0d", bus.b_valid, bus.b_resp, er); end
    n_cmp++; if (regs_o[1*DW +: DW] !== 32'hAAAA5678) begin n_fail++; $display("FAIL stag_reg1: got %h want aaaa5678", regs_o[1*DW +: DW]); end
    bus.b_ready = 1;
    step();
    bus.b_ready = 0;
  endtask

  task automatic test_miss();
    resp_t r, er;
    bit ok;
    logic [31:0] d;
    er = model_write(32'h40, 32'hCAFEF00D, 4'hF);
    drive_write(32'h40, 32'hCAFEF00D, 4'hF, 1, 0, 2, r, ok);
    n_cmp++; if (!ok || r !== er || er !== RESP_DECERR) begin n_fail++; $display("FAIL miss_wr_resp: ok %b got %0d want %0d", ok, r, er); end
    n_cmp++; if (regs_o !== model_vec()) begin n_fail++; $display("FAIL miss_wr_regs: got %h want %h", regs_o, model_vec()); end
    drive_read(32'h40, 1, d, r, ok);
    n_cmp++; if (!ok || d !== 32'h0 || r !== RESP_DECERR) begin n_fail++; $display("FAIL miss_rd: ok %b data %h resp %0d want 1 0 3", ok, d, r); end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_d;
    exp_d = model_read_data(32'h08);
    bus.ar_valid = 1; bus.ar_addr = 32'h08;
    step();
    bus.ar_valid = 0;
    for (int c = 0; c < 5; c++) begin
      n_cmp++;
      if (bus.r_valid !== 1'b1 || bus.r_data !== exp_d || bus.ar_ready !== 1'b0 || bus.r_resp !== RESP_OKAY) begin
        n_fail++;
        $display("FAIL bp_hold c%0d: valid %b data %h ar_ready %b resp %0d want 1 %h 0 0", c, bus.r_valid, bus.r_data, bus.ar_ready, bus.r_resp, exp_d);
      end
      step();
    end
    bus.r_ready = 1;
    step();
    bus.r_ready = 0;
    n_cmp++; if (bus.r_valid !== 1'b0 || bus.ar_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release: valid %b ar_ready %b want 0 1", bus.r_valid, bus.ar_ready); end
  endtask

  task automatic test_independent();
    resp_t r, er;
    bit ok;
    logic [31:0] d;
    er = model_write(32'h14, 32'h0BADC0DE, 4'hF);
    bus.aw_valid = 1; bus.aw_addr = 32'h14;
    bus.w_valid = 1; bus.w_data = 32'h0BADC0DE; bus.w_strb = 4'hF;
    step();
    bus.aw_valid = 0; bus.w_valid = 0;
    drive_read(32'h14, 0, d, r, ok);
    n_cmp++; if (!ok || d !== model_read_data(32'h14)) begin n_fail++; $display("FAIL indep_read: ok %b data %h want %h", ok, d, model_read_data(32'h14)); end
    n_cmp++; if (bus.b_valid !== 1'b1 || bus.b_resp !== er) begin n_fail++; $display("FAIL indep_b_pending: got %b/%0d want 1/%0d", bus.b_valid, bus.b_resp, er); end
    bus.b_ready = 1;
    step();
    bus.b_ready = 0;
  endtask

  task automatic test_collision();
    resp_t r, er;
    bit ok;
    logic [31:0] d;
    er = model_write(32'h0C, 32'h11, 4'hF);
    drive_write(32'h0C, 32'h11, 4'hF, 0, 0, 0, r, ok);
    n_cmp++; if (!ok || r !== er) begin n_fail++; $display("FAIL coll_prefill: ok %b resp %0d want 1 %0d", ok, r, er); end
    bus.aw_valid = 1; bus.aw_addr = 32'h0C;
    bus.w_valid = 1; bus.w_data = 32'h55; bus.w_strb = 4'hF;
    bus.ar_valid = 1; bus.ar_addr = 32'h0C;
    step();
    bus.aw_valid = 0; bus.w_valid = 0; bus.ar_valid = 0;
    n_cmp++; if (bus.r_valid !== 1'b1 || bus.r_data !== 32'h11) begin n_fail++; $display("FAIL coll_old: valid %b data %h want 1 11", bus.r_valid, bus.r_data); end
    er = model_write(32'h0C, 32'h55, 4'hF);
    bus.b_ready = 1; bus.r_ready = 1;
    step();
    bus.b_ready = 0; bus.r_ready = 0;
    drive_read(32'h0C, 0, d, r, ok);
    n_cmp++; if (!ok || d !== 32'h55 || r !== er) begin n_fail++; $display("FAIL coll_new: ok %b data %h resp %0d want 1 55 %0d", ok, d, r, er); end
  endtask

  task automatic test_random();
    resp_t r, er;
    bit ok;
    logic [31:0] addr, data, ed;
    logic [3:0]  strb;
    for (int t = 0; t < 60; t++) begin
      addr = 32'($urandom_range(0, NREG + 3)) * 4 + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        data = $urandom();
        strb = 4'($urandom_range(0, 15));
        er = model_write(addr, data, strb);
        drive_write(addr, data, strb, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), r, ok);
        n_cmp++; if (!ok || r !== er) begin n_fail++; $display("FAIL rand_wr t%0d addr %h: ok %b resp %0d want 1 %0d", t, addr, ok, r, er); end
      end else begin
        ed = model_read_data(addr);
        er = model_read_resp(addr);
        drive_read(addr, $urandom_range(0, 3), data, r, ok);
        n_cmp++; if (!ok || data !== ed || r !== er) begin n_fail++; $display("FAIL rand_rd t%0d addr %h: ok %b data %h resp %0d want 1 %h %0d", t, addr, ok, data, r, ed, er); end
      end
    end
    n_cmp++; if (regs_o !== model_vec()) begin n_fail++; $display("FAIL rand_regs: got %h want %h", regs_o, model_vec()); end
  endtask

  task automatic test_reset_mid_write();
    resp_t r, er;
    bit ok;
    bus.aw_valid = 1; bus.aw_addr = 32'h08;
    step();
    bus.aw_valid = 0;
    n_cmp++; if (bus.aw_ready !== 1'b0) begin n_fail++; $display("FAIL rmw_aw_taken: got %b want 0", bus.aw_ready); end
    rstn = 0;
    for (int i = 0; i < NREG; i++) model[i] = '0;
    #1;
    n_cmp++; if ({bus.aw_ready, bus.w_ready, bus.ar_ready, bus.b_valid, bus.r_valid} !== 5'b11100) begin n_fail++; $display("FAIL rmw_in_reset: got %b want 11100", {bus.aw_ready, bus.w_ready, bus.ar_ready, bus.b_valid, bus.r_valid}); end
    n_cmp++; if (regs_o !== model_vec()) begin n_fail++; $display("FAIL rmw_regs: got %h want %h", regs_o, model_vec()); end
    step(); step();
    rstn = 1;
    bus.w_valid = 1; bus.w_data = 32'h77777777; bus.w_strb = 4'hF;
    step();
    bus.w_valid = 0;
    step(); step();
    n_cmp++; if ({bus.b_valid, bus.aw_ready} !== 2'b01) begin n_fail++; $display("FAIL rmw_no_b: got %b want 01", {bus.b_valid, bus.aw_ready}); end
    bus.aw_valid = 1; bus.aw_addr = 32'h20;
    step();
    bus.aw_valid = 0;
    er = model_write(32'h20, 32'h77777777, 4'hF);
    n_cmp++; if (bus.b_valid !== 1'b1 || regs_o[8*DW +: DW] !== 32'h77777777) begin n_fail++; $display("FAIL rmw_resume: b %b reg8 %h want 1 77777777", bus.b_valid, regs_o[8*DW +: DW]); end
    bus.b_ready = 1;
    step();
    bus.b_ready = 0;
    er = model_write(32'h08, 32'h01020304, 4'hF);
    drive_write(32'h08, 32'h01020304, 4'hF, 0, 1, 0, r, ok);
    n_cmp++; if (!ok || r !== er || regs_o !== model_vec()) begin n_fail++; $display("FAIL rmw_after: ok %b resp %0d regs %h want %h", ok, r, regs_o, model_vec()); end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rstn = 0;
    bus.aw_valid = 0; bus.aw_addr = '0;
    bus.w_valid = 0; bus.w_data = '0; bus.w_strb = '0;
    bus.b_ready = 0;
    bus.ar_valid = 0; bus.ar_addr = '0;
    bus.r_ready = 0;
    for (int i = 0; i < NREG; i++) model[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rstn = 1;
    step();
    test_reset();
    test_same_cycle_write();
    test_staggered_write();
    test_miss();
    test_backpressure();
    test_independent();
    test_collision();
    test_random();
    test_reset_mid_write();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_cmp++;
    n_fail++;
    $display("FAIL watchdog: run exceeded 200000 ns");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
